// File: rtl/mini_core_dmem_arb.sv
// -----------------------------------------------------------------------------
// mini_core_dmem_arb
//
// Shares the single D_MEM port between the core's Q103H memory-access stage and
// an external requester (debug / fabric loader). By default the core wins a
// conflict. A starvation counter makes sure the external requester wins after
// MAX_EXT_WAIT consecutive lost cycles. Each accepted read is tracked for one
// cycle, so the D_MEM read data that arrives the next cycle is flagged as valid
// toward the requester that owns it.
//
// Ports
//   Clock, Rst          : core clock, asynchronous active-low reset
//   CoreReq*            : core request (valid, addr, store data, byte enables,
//                         write / read strobes); held stable until accepted
//   DMemReady           : back-pressure to the core (1 = accepted or idle)
//   CoreRdRsp*          : core load response (valid flag plus data)
//   ExtReq*             : external request, same fields as the core request
//   ExtReqReady         : external request accepted this cycle
//   ExtRdRsp*           : external load response (valid flag plus data)
//   Mem*                : request presented to D_MEM (all zero when idle)
//   MemAccept           : D_MEM takes the presented request this cycle
//   MemRdData           : D_MEM read data, one cycle after an accepted read
// -----------------------------------------------------------------------------
module mini_core_dmem_arb #(
    parameter int MAX_EXT_WAIT = 4,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic        Clock,
    input  logic        Rst,

    input  logic        CoreReqValid,
    input  logic [31:0] CoreReqAddr,
    input  logic [31:0] CoreReqWrData,
    input  logic [3:0]  CoreReqByteEn,
    input  logic        CoreReqWrEn,
    input  logic        CoreReqRdEn,
    output logic        DMemReady,
    output logic        CoreRdRspValid,
    output logic [31:0] CoreRdRspData,

    input  logic        ExtReqValid,
    input  logic [31:0] ExtReqAddr,
    input  logic [31:0] ExtReqWrData,
    input  logic [3:0]  ExtReqByteEn,
    input  logic        ExtReqWrEn,
    input  logic        ExtReqRdEn,
    output logic        ExtReqReady,
    output logic        ExtRdRspValid,
    output logic [31:0] ExtRdRspData,

    output logic        MemReqValid,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemByteEn,
    output logic        MemWrEn,
    output logic        MemRdEn,
    input  logic        MemAccept,
    input  logic [31:0] MemRdData
);

    localparam logic [WAIT_CNT_W-1:0] WaitLimit = WAIT_CNT_W'(MAX_EXT_WAIT);

    logic [WAIT_CNT_W-1:0] waitCnt;
    logic                  extPri;
    logic                  gntExt;
    logic                  gntCore;
    logic                  rdAccept;
    logic                  rdPend_p1;
    logic                  rdOwner_p1;

    // Grant: all requests are masked while reset is held so nothing reaches
    // D_MEM and neither requester sees an accept.
    assign extPri  = (waitCnt >= WaitLimit);
    assign gntExt  = Rst & ExtReqValid & (~CoreReqValid | extPri);
    assign gntCore = Rst & CoreReqValid & ~gntExt;

    assign MemReqValid = gntCore | gntExt;
    assign DMemReady   = Rst & (~CoreReqValid | (gntCore & MemAccept));
    assign ExtReqReady = gntExt & MemAccept;

    always_comb begin
        MemAddr   = '0;
        MemWrData = '0;
        MemByteEn = '0;
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        if (gntExt) begin
            MemAddr   = ExtReqAddr;
            MemWrData = ExtReqWrData;
            MemByteEn = ExtReqByteEn;
            MemWrEn   = ExtReqWrEn;
            MemRdEn   = ExtReqRdEn;
        end else if (gntCore) begin
            MemAddr   = CoreReqAddr;
            MemWrData = CoreReqWrData;
            MemByteEn = CoreReqByteEn;
            MemWrEn   = CoreReqWrEn;
            MemRdEn   = CoreReqRdEn;
        end
    end

    // Starvation counter: counts consecutive cycles the external request waits,
    // including cycles lost only because D_MEM did not accept.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            waitCnt <= '0;
        end else if (ExtReqValid && !ExtReqReady) begin
            if (waitCnt != '1) begin
                waitCnt <= waitCnt + WAIT_CNT_W'(1);
            end
        end else begin
            waitCnt <= '0;
        end
    end

    // Stage p0 -> p1: remember whether this cycle's accept was a read and who
    // owns it. Reloaded every cycle so back-to-back reads need no extra state.
    assign rdAccept = MemReqValid & MemAccept & MemRdEn;

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            rdPend_p1  <= 1'b0;
            rdOwner_p1 <= 1'b0;
        end else begin
            rdPend_p1  <= rdAccept;
            rdOwner_p1 <= rdAccept & gntExt;
        end
    end

    // Stage p1: D_MEM data goes to both requesters; only the valid flag steers.
    assign CoreRdRspValid = rdPend_p1 & ~rdOwner_p1;
    assign ExtRdRspValid  = rdPend_p1 & rdOwner_p1;
    assign CoreRdRspData  = MemRdData;
    assign ExtRdRspData   = MemRdData;

    // A request that is both a load and a store has no defined meaning.
    coreRdWrExclusive: assert property (@(posedge Clock) disable iff (!Rst)
        !(CoreReqValid && CoreReqRdEn && CoreReqWrEn));
    extRdWrExclusive: assert property (@(posedge Clock) disable iff (!Rst)
        !(ExtReqValid && ExtReqRdEn && ExtReqWrEn));

endmodule

// File: tb/tb_mini_core_dmem_arb.sv
module tb_mini_core_dmem_arb;

    localparam int MAXW = 4;

    logic        Clock = 1'b0;
    logic        Rst;
    logic        CoreReqValid, CoreReqWrEn, CoreReqRdEn;
    logic [31:0] CoreReqAddr, CoreReqWrData;
    logic [3:0]  CoreReqByteEn;
    logic        DMemReady, CoreRdRspValid;
    logic [31:0] CoreRdRspData;
    logic        ExtReqValid, ExtReqWrEn, ExtReqRdEn;
    logic [31:0] ExtReqAddr, ExtReqWrData;
    logic [3:0]  ExtReqByteEn;
    logic        ExtReqReady, ExtRdRspValid;
    logic [31:0] ExtRdRspData;
    logic        MemReqValid, MemWrEn, MemRdEn, MemAccept;
    logic [31:0] MemAddr, MemWrData, MemRdData;
    logic [3:0]  MemByteEn;

    mini_core_dmem_arb #(.MAX_EXT_WAIT(MAXW), .WAIT_CNT_W(8)) dut (
        .Clock(Clock), .Rst(Rst),
        .CoreReqValid(CoreReqValid), .CoreReqAddr(CoreReqAddr),
        .CoreReqWrData(CoreReqWrData), .CoreReqByteEn(CoreReqByteEn),
        .CoreReqWrEn(CoreReqWrEn), .CoreReqRdEn(CoreReqRdEn),
        .DMemReady(DMemReady), .CoreRdRspValid(CoreRdRspValid),
        .CoreRdRspData(CoreRdRspData),
        .ExtReqValid(ExtReqValid), .ExtReqAddr(ExtReqAddr),
        .ExtReqWrData(ExtReqWrData), .ExtReqByteEn(ExtReqByteEn),
        .ExtReqWrEn(ExtReqWrEn), .ExtReqRdEn(ExtReqRdEn),
        .ExtReqReady(ExtReqReady), .ExtRdRspValid(ExtRdRspValid),
        .ExtRdRspData(ExtRdRspData),
        .MemReqValid(MemReqValid), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemByteEn(MemByteEn), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn),
        .MemAccept(MemAccept), .MemRdData(MemRdData)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        v, rd, wr;
        logic [31:0] addr, wd;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        dr, er, mv, we, re;
        logic [31:0] a, wd;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        ext;
        logic [31:0] data;
    } rsp_t;

    exp_t expQ[$];
    rsp_t rspQ[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus state
    req_t        cReq, eReq;
    logic        rstV, memAcc;
    logic        useFixed;
    logic [31:0] fixedData;
    logic [31:0] memRdNext;

    // reference model state
    int   waitM = 0;
    logic accC, accE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, req);
        end
    endtask

    function automatic req_t idleReq();
        req_t r;
        r.v = 0; r.rd = 0; r.wr = 0; r.addr = '0; r.wd = '0; r.be = '0;
        return r;
    endfunction

    function automatic req_t mkReq(input logic rd, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [3:0] be);
        req_t r;
        r.v = 1; r.rd = rd; r.wr = !rd; r.addr = addr; r.wd = wd; r.be = be;
        return r;
    endfunction

    function automatic req_t rndReq();
        return mkReq(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    endfunction

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic step();
        exp_t        e;
        req_t        w;
        logic        extWins, coreWins;
        logic [31:0] d;
        @(negedge Clock);
        cyc++;
        Rst           = rstV;
        CoreReqValid  = cReq.v;  CoreReqRdEn = cReq.rd; CoreReqWrEn = cReq.wr;
        CoreReqAddr   = cReq.addr; CoreReqWrData = cReq.wd; CoreReqByteEn = cReq.be;
        ExtReqValid   = eReq.v;  ExtReqRdEn = eReq.rd; ExtReqWrEn = eReq.wr;
        ExtReqAddr    = eReq.addr; ExtReqWrData = eReq.wd; ExtReqByteEn = eReq.be;
        MemAccept     = memAcc;
        MemRdData     = memRdNext;

        e.dr = 0; e.er = 0; e.mv = 0; e.we = 0; e.re = 0; e.a = '0; e.wd = '0; e.be = '0;
        accC = 0; accE = 0;
        memRdNext = $urandom;
        if (!rstV) begin
            waitM = 0;
            rspQ.delete();
        end else begin
            extWins  = eReq.v && (!cReq.v || waitM >= MAXW);
            coreWins = cReq.v && !extWins;
            accC = coreWins && memAcc;
            accE = extWins && memAcc;
            e.dr = !cReq.v || accC;
            e.er = accE;
            if (extWins || coreWins) begin
                w = extWins ? eReq : cReq;
                e.mv = 1; e.a = w.addr; e.wd = w.wd; e.be = w.be; e.we = w.wr; e.re = w.rd;
                if (memAcc && w.rd) begin
                    d = useFixed ? fixedData : $urandom;
                    rspQ.push_back('{cyc: cyc + 1, ext: extWins, data: d});
                    memRdNext = d;
                end
            end
            if (eReq.v && !accE) waitM = (waitM >= 255) ? 255 : waitM + 1;
            else                 waitM = 0;
        end
        expQ.push_back(e);
    endtask

    // Monitor: compares each cycle's outputs against what the model queued.
    always begin
        exp_t e;
        rsp_t r;
        logic hasRsp;
        @(negedge Clock);
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("DMemReady",   32'(DMemReady),   32'(e.dr));
            chk("ExtReqReady", 32'(ExtReqReady), 32'(e.er));
            chk("MemReqValid", 32'(MemReqValid), 32'(e.mv));
            chk("MemAddr",     MemAddr,          e.a);
            chk("MemWrData",   MemWrData,        e.wd);
            chk("MemByteEn",   32'(MemByteEn),   32'(e.be));
            chk("MemWrEn",     32'(MemWrEn),     32'(e.we));
            chk("MemRdEn",     32'(MemRdEn),     32'(e.re));
            hasRsp = (rspQ.size() > 0) && (rspQ[0].cyc == cyc);
            if (hasRsp) begin
                r = rspQ.pop_front();
                chk("CoreRdRspValid", 32'(CoreRdRspValid), 32'(!r.ext));
                chk("ExtRdRspValid",  32'(ExtRdRspValid),  32'(r.ext));
                chk(r.ext ? "ExtRdRspData" : "CoreRdRspData",
                    r.ext ? ExtRdRspData : CoreRdRspData, r.data);
            end else begin
                chk("CoreRdRspValid", 32'(CoreRdRspValid), 32'(0));
                chk("ExtRdRspValid",  32'(ExtRdRspValid),  32'(0));
            end
        end
    end

    initial begin
        rstV = 0; memAcc = 1; useFixed = 0; fixedData = '0; memRdNext = '0;
        Rst = 0;
        CoreReqValid = 0; CoreReqRdEn = 0; CoreReqWrEn = 0;
        CoreReqAddr = '0; CoreReqWrData = '0; CoreReqByteEn = '0;
        ExtReqValid = 0; ExtReqRdEn = 0; ExtReqWrEn = 0;
        ExtReqAddr = '0; ExtReqWrData = '0; ExtReqByteEn = '0;
        MemAccept = 0; MemRdData = '0;

        // Reset held with both requesters active: everything gated off.
        cReq = mkReq(1, 32'h40, 0, 4'hF);
        eReq = mkReq(1, 32'h80, 0, 4'hF);
        repeat (3) step();
        cReq = idleReq(); eReq = idleReq();
        rstV = 1;
        step();

        // Core-only load with fixed read data.
        useFixed = 1; fixedData = 32'hDEADBEEF;
        cReq = mkReq(1, 32'h100, 0, 4'hF);
        step();
        cReq = idleReq();
        step();
        useFixed = 0;

        // External-only store.
        eReq = mkReq(0, 32'h200, 32'h12345678, 4'hF);
        step();
        eReq = idleReq();
        step();

        // Continuous core loads against a held external load: forced win.
        cReq = mkReq(1, 32'h300, 0, 4'hF);
        eReq = mkReq(1, 32'h400, 0, 4'hF);
        repeat (5) step();
        eReq = idleReq();
        step();
        cReq = idleReq();
        step();

        // Back-to-back reads core / ext / core.
        cReq = mkReq(1, 32'h500, 0, 4'h3);
        step();
        cReq = idleReq(); eReq = mkReq(1, 32'h504, 0, 4'hC);
        step();
        eReq = idleReq(); cReq = mkReq(1, 32'h508, 0, 4'hF);
        step();
        cReq = idleReq();
        step();

        // D_MEM stalls three cycles on a core store, then accepts.
        cReq = mkReq(0, 32'h600, 32'hA5A5_5A5A, 4'h6);
        memAcc = 0;
        repeat (3) step();
        memAcc = 1;
        step();
        cReq = idleReq();
        step();

        // Reset the cycle after an accepted read: response discarded.
        cReq = mkReq(1, 32'h700, 0, 4'hF);
        step();
        cReq = idleReq();
        rstV = 0;
        step();
        rstV = 1;
        repeat (2) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            memAcc = ($urandom_range(0, 3) != 0);
            step();
            if (accC || !cReq.v) cReq = ($urandom_range(0, 2) != 0) ? rndReq() : idleReq();
            if (accE || !eReq.v) eReq = ($urandom_range(0, 1) != 0) ? rndReq() : idleReq();
        end
        cReq = idleReq(); eReq = idleReq();
        repeat (3) step();
        @(negedge Clock);
        #4;
        chk("PendingRsp", 32'(rspQ.size()), 32'(0));
        chk("PendingExp", 32'(expQ.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mini_core_dmem_arb.md
Name: mini_core_dmem_arb

Overview:
Two-requester arbiter that shares the single D_MEM port between the mini core's Q103H memory-access stage and an external requester (debug/fabric loader). The core has default priority. A starvation counter guarantees the external requester a grant within a bounded wait. The block tracks each outstanding read and routes the one-cycle-later read response back to its owner, and it drives the core's DMemReady back-pressure.

Parameters:
MAX_EXT_WAIT, 4, consecutive cycles an external request may lose arbitration before it is forced to win (range 1..255)
WAIT_CNT_W, 8, width of the starvation counter

Ports:
Clock  input  1  core clock
Rst  input  1  asynchronous active-low reset; Rst=0 resets
CoreReqValid  input  1  core Q103H request (RdEn or WrEn set)
CoreReqAddr  input  32  byte address
CoreReqWrData  input  32  store data
CoreReqByteEn  input  4  byte enables
CoreReqWrEn  input  1  store
CoreReqRdEn  input  1  load
DMemReady  output  1  to core; 1 = core request accepted this cycle (or no core request)
CoreRdRspValid  output  1  core load data valid (Q104H)
CoreRdRspData  output  32  core load data
ExtReqValid  input  1  external request
ExtReqAddr  input  32  byte address
ExtReqWrData  input  32  store data
ExtReqByteEn  input  4  byte enables
ExtReqWrEn  input  1  store
ExtReqRdEn  input  1  load
ExtReqReady  output  1  external request accepted this cycle
ExtRdRspValid  output  1  external load data valid
ExtRdRspData  output  32  external load data
MemReqValid  output  1  request to D_MEM
MemAddr  output  32  to D_MEM
MemWrData  output  32  to D_MEM
MemByteEn  output  4  to D_MEM
MemWrEn  output  1  to D_MEM
MemRdEn  output  1  to D_MEM
MemAccept  input  1  D_MEM accepts the presented request this cycle
MemRdData  input  32  D_MEM read data, valid exactly 1 cycle after an accepted read

Behaviour:
- Reset (Rst=0, asynchronous): WaitCnt=0; RdPend=0; RdOwner=0; CoreRdRspValid=0; ExtRdRspValid=0. While Rst=0, MemReqValid=0, DMemReady=0 and ExtReqReady=0 (combinational gating).
- Grant (combinational, each cycle):
  - ExtPri = (WaitCnt >= MAX_EXT_WAIT).
  - GntExt = ExtReqValid & (~CoreReqValid | ExtPri).
  - GntCore = CoreReqValid & ~GntExt.
- The Mem* outputs mux the granted requester's fields. MemReqValid = GntCore | GntExt. When there is no grant, all Mem* outputs are 0.
- Accept:
  - DMemReady = ~CoreReqValid | (GntCore & MemAccept).
  - ExtReqReady = GntExt & MemAccept.
  - A requester holds all its fields stable until accepted. The arbiter never drops a request.
- Starvation counter:
  - Increments, saturating at 2^WAIT_CNT_W-1, each cycle ExtReqValid=1 and the external request is not accepted.
  - Clears to 0 on external accept or when ExtReqValid=0.
  - A forced external win blocks the core for that cycle (DMemReady=0).
- Read tracking:
  - On an accepted read (MemReqValid & MemAccept & MemRdEn): next cycle RdPend=1 and RdOwner = 1 if external, 0 if core.
  - Otherwise RdPend=0 next cycle.
  - Back-to-back reads are allowed: RdPend and RdOwner reload every cycle.
- Response:
  - CoreRdRspValid = RdPend & ~RdOwner; ExtRdRspValid = RdPend & RdOwner (registered flags).
  - Both Rsp data outputs = MemRdData (combinational pass-through; only the valid flags steer).
  - Writes produce no response.
- A request with both RdEn=1 and WrEn=1 is illegal. Assertion required; behaviour is undefined.
- Simultaneous core and external requests, WaitCnt < MAX_EXT_WAIT: the core wins and the counter increments.
- MemAccept=0: no accept; the grant re-evaluates the next cycle. The counter still increments if the external request is waiting.
- Reset mid-read: a pending response is discarded, and no valid is asserted after reset release.
- Latency: request-to-accept is 0 cycles when uncontended and MemAccept=1; read response is 1 cycle after accept.

Test Plan:
- Core-only load, addr 0x100, MemAccept=1, MemRdData=0xDEADBEEF next cycle -> DMemReady=1 in the request cycle; next cycle CoreRdRspValid=1 with data 0xDEADBEEF; ExtRdRspValid=0.
- Ext-only store, addr 0x200, data 0x12345678, ByteEn=0xF -> ExtReqReady=1 same cycle; MemWrEn=1 with matching fields; no response valid.
- Continuous core loads plus a held ext load, MAX_EXT_WAIT=4 -> ext loses 4 cycles (WaitCnt 1..4); cycle 5 GntExt=1, DMemReady=0, ExtReqReady=1; next cycle ExtRdRspValid=1 and WaitCnt=0.
- Alternating accepted reads core/ext/core, back-to-back -> response valids follow the owner order core, ext, core, each exactly 1 cycle after its accept.
- MemAccept=0 for 3 cycles with a core request -> DMemReady=0 for 3 cycles, Mem* fields stable; accept on the 4th cycle.
- Rst driven low the cycle after an accepted read -> CoreRdRspValid=0 immediately, and it stays 0 after Rst returns to 1.
